// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked data memory with programmable wait states.
// Accepts one request at a time, holds the requester busy for WAIT_CYCLES
// extra cycles, commits a byte-masked write or captures the read word on the
// edge that enters RESP, then pulses mem_ack for one cycle.
// Optional feature macro: DATA_MEM_PARITY_EN (per-lane even parity, mem_err).
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   mem_req          request strobe, sampled in IDLE/RESP only
//   mem_write_en     1 = write, 0 = read
//   mem_byte_en      byte-lane write mask (bit k -> bits [8k+7:8k])
//   mem_access_addr  word address
//   mem_write_data   write data
//   mem_read_data    registered read data, held until the next read ack
//   mem_ack          one-cycle completion pulse
//   mem_busy         high in WAIT and RESP
//   mem_err          lane parity mismatch on a read ack (0 without parity)
//
// state | meaning
// IDLE  | no request in flight, accepting mem_req
// WAIT  | request latched, counting down wait states, inputs ignored
// RESP  | ack cycle; a new request may be accepted back-to-back
module data_mem_hs #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_req,
  input  logic                    mem_write_en,
  input  logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic [ADDR_WIDTH-1:0]   mem_access_addr,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    mem_ack,
  output logic                    mem_busy,
  output logic                    mem_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_hs: WAIT_CYCLES must be 0..15");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("data_mem_hs: DATA_WIDTH must be a positive multiple of 8");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [NB-1:0]           r_be;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_ack;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_ram [DEPTH];

  logic                    w_accept;
  logic                    w_wait_done;
  logic                    w_commit;
  logic                    w_c_we;
  logic [NB-1:0]           w_c_be;
  logic [ADDR_WIDTH-1:0]   w_c_addr;
  logic [DATA_WIDTH-1:0]   w_c_wdata;

  assign w_accept    = (r_state == ST_IDLE || r_state == ST_RESP) && mem_req;
  assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == 4'd1);
  // With zero wait states the accepting edge is also the commit edge, so the
  // commit must take the live inputs rather than the not-yet-latched copies.
  assign w_commit    = (w_accept && (WAIT_CYCLES == 0)) || w_wait_done;
  assign w_c_we      = w_wait_done ? r_we    : mem_write_en;
  assign w_c_be      = w_wait_done ? r_be    : mem_byte_en;
  assign w_c_addr    = w_wait_done ? r_addr  : mem_access_addr;
  assign w_c_wdata   = w_wait_done ? r_wdata : mem_write_data;

`ifdef DATA_MEM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic          r_err;
  logic [NB-1:0] w_par_bad;

  always_comb begin
    w_par_bad = '0;
    for (int k = 0; k < NB; k++)
      w_par_bad[k] = (^r_ram[w_c_addr][8*k +: 8]) ^ r_par[w_c_addr][k];
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_c_we) begin
      for (int k = 0; k < NB; k++)
        if (w_c_be[k]) r_par[w_c_addr][k] <= ^w_c_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                   r_err <= 1'b0;
    else if (w_commit && !w_c_we) r_err <= |w_par_bad;
    else                          r_err <= 1'b0;
  end

  assign mem_err = r_err;
`else
  assign mem_err = 1'b0;
`endif

  // RAM is never cleared; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_c_we) begin
      for (int k = 0; k < NB; k++)
        if (w_c_be[k]) r_ram[w_c_addr][8*k +: 8] <= w_c_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (mem_req) begin
            r_we    <= mem_write_en;
            r_be    <= mem_byte_en;
            r_addr  <= mem_access_addr;
            r_wdata <= mem_write_data;
            r_cnt   <= WAIT_LD;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_RESP;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_commit) begin
        r_ack <= 1'b1;
        if (!w_c_we) r_rdata <= r_ram[w_c_addr];
      end
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_ack       = r_ack;
  assign mem_busy      = r_busy;

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: three instances with WAIT_CYCLES 1, 0, 3.
// Stimulus pushes the expected ack (cycle, read data, error) per instance;
// a negedge monitor pops and compares whenever an instance acks.
module tb_data_mem_hs;

  typedef struct {
    int          exp_cyc;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n [3];
  logic        req   [3];
  logic        we    [3];
  logic [1:0]  be    [3];
  logic [7:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic        busy  [3];
  logic        err   [3];

  exp_t        sb [3][$];
  logic [15:0] lastrd [3];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  data_mem_hs #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n[0]), .mem_req(req[0]), .mem_write_en(we[0]),
    .mem_byte_en(be[0]), .mem_access_addr(addr[0]), .mem_write_data(wdata[0]),
    .mem_read_data(rdata[0]), .mem_ack(ack[0]), .mem_busy(busy[0]), .mem_err(err[0]));

  data_mem_hs #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n[1]), .mem_req(req[1]), .mem_write_en(we[1]),
    .mem_byte_en(be[1]), .mem_access_addr(addr[1]), .mem_write_data(wdata[1]),
    .mem_read_data(rdata[1]), .mem_ack(ack[1]), .mem_busy(busy[1]), .mem_err(err[1]));

  data_mem_hs #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n[2]), .mem_req(req[2]), .mem_write_en(we[2]),
    .mem_byte_en(be[2]), .mem_access_addr(addr[2]), .mem_write_data(wdata[2]),
    .mem_read_data(rdata[2]), .mem_ack(ack[2]), .mem_busy(busy[2]), .mem_err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int i);
    if (i == 0) return 1;
    if (i == 1) return 0;
    return 3;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack inst=%0d cyc=%0d got=ack want=no_ack", i, cyc);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          chk("ack_cycle", i, 32'(cyc), 32'(e.exp_cyc));
          chk("read_data", i, {16'h0, rdata[i]}, {16'h0, e.data});
          chk("mem_err",   i, {31'h0, err[i]},   {31'h0, e.err});
        end
      end
    end
  end

  // Push the expectation for a request driven in the current cycle.
  task automatic push_exp(input int i, input bit is_wr, input logic [15:0] rd,
                          input logic e_err, input int ack_cyc);
    exp_t e;
    e.exp_cyc = ack_cyc;
    e.data    = is_wr ? lastrd[i] : rd;
    e.err     = e_err;
    if (!is_wr) lastrd[i] = rd;
    sb[i].push_back(e);
  endtask

  task automatic drive(input int i, input bit w, input logic [1:0] b,
                       input logic [7:0] a, input logic [15:0] d);
    we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d; req[i] = 1'b1;
  endtask

  // Entered and left at posedge+1 with the instance idle.
  task automatic drain(input int i);
    for (int n = 0; n < 40 && sb[i].size() != 0; n++) @(posedge clk);
    #1;
    if (sb[i].size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout inst=%0d got=%0d_pending want=0", i, sb[i].size());
      sb[i].delete();
    end
  endtask

  task automatic issue(input int i, input bit w, input logic [1:0] b,
                       input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err);
    drive(i, w, b, a, d);
    push_exp(i, w, exp_rd, exp_err, cyc + wait_of(i) + 1);
    @(posedge clk); #1;
    req[i] = 1'b0;
    chk("busy_after_accept", i, {31'h0, busy[i]}, 32'h1);
    drain(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; be[i] = 2'b00;
      addr[i] = 8'h00; wdata[i] = 16'h0000; lastrd[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rdata", i, {16'h0, rdata[i]}, 32'h0);
      chk("rst_ack",   i, {31'h0, ack[i]},   32'h0);
      chk("rst_busy",  i, {31'h0, busy[i]},  32'h0);
      chk("rst_err",   i, {31'h0, err[i]},   32'h0);
      rst_n[i] = 1'b1;
    end
    @(posedge clk); #1;

    // WAIT_CYCLES=1: basic write/read, ack in cycle 2 after the req cycle.
    issue(0, 1'b1, 2'b11, 8'h12, 16'hBEEF, 16'h0000, 1'b0);
    issue(0, 1'b0, 2'b00, 8'h12, 16'h0000, 16'hBEEF, 1'b0);

    // Byte lanes.
    issue(0, 1'b1, 2'b11, 8'h05, 16'h1234, 16'h0000, 1'b0);
    issue(0, 1'b1, 2'b01, 8'h05, 16'hABCD, 16'h0000, 1'b0);
    issue(0, 1'b0, 2'b11, 8'h05, 16'h0000, 16'h12CD, 1'b0);
    issue(0, 1'b1, 2'b00, 8'h05, 16'hFFFF, 16'h0000, 1'b0);
    issue(0, 1'b0, 2'b00, 8'h05, 16'h0000, 16'h12CD, 1'b0);
    issue(0, 1'b1, 2'b10, 8'h05, 16'h9900, 16'h0000, 1'b0);
    issue(0, 1'b0, 2'b00, 8'h05, 16'h0000, 16'h99CD, 1'b0);

    // WAIT_CYCLES=0 back-to-back: write then read the same word, no bubble.
    drive(1, 1'b1, 2'b11, 8'h20, 16'h5555);
    push_exp(1, 1'b1, 16'h0000, 1'b0, cyc + 1);
    @(posedge clk); #1;
    chk("b2b_busy_1", 1, {31'h0, busy[1]}, 32'h1);
    drive(1, 1'b0, 2'b00, 8'h20, 16'h0000);
    push_exp(1, 1'b0, 16'h5555, 1'b0, cyc + 1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("b2b_busy_2", 1, {31'h0, busy[1]}, 32'h1);
    drain(1);
    chk("b2b_idle", 1, {31'h0, busy[1]}, 32'h0);

    // WAIT_CYCLES=3: reset one cycle after acceptance drops the write.
    issue(2, 1'b1, 2'b11, 8'h30, 16'h0000, 16'h0000, 1'b0);
    drive(2, 1'b1, 2'b11, 8'h30, 16'hFFFF);
    @(posedge clk); #1;
    req[2] = 1'b0;
    rst_n[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    lastrd[2] = 16'h0000;
    chk("rst_mid_busy", 2, {31'h0, busy[2]}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    issue(2, 1'b0, 2'b00, 8'h30, 16'h0000, 16'h0000, 1'b0);

    // Request during WAIT is ignored: exactly one ack, 0x40 untouched.
    issue(2, 1'b1, 2'b11, 8'h40, 16'h1111, 16'h0000, 1'b0);
    drive(2, 1'b1, 2'b11, 8'h50, 16'h7777);
    push_exp(2, 1'b1, 16'h0000, 1'b0, cyc + 4);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    drive(2, 1'b1, 2'b11, 8'h40, 16'h9999);
    @(posedge clk); #1;
    req[2] = 1'b0;
    chk("wait_busy", 2, {31'h0, busy[2]}, 32'h1);
    drain(2);
    repeat (6) @(posedge clk);
    #1;
    issue(2, 1'b0, 2'b00, 8'h40, 16'h0000, 16'h1111, 1'b0);
    issue(2, 1'b0, 2'b00, 8'h50, 16'h0000, 16'h7777, 1'b0);

`ifdef DATA_MEM_PARITY_EN
    issue(0, 1'b1, 2'b11, 8'h08, 16'h0F0F, 16'h0000, 1'b0);
    u_w1.r_par[8][0] = ~u_w1.r_par[8][0];
    issue(0, 1'b0, 2'b00, 8'h08, 16'h0000, 16'h0F0F, 1'b1);
    issue(0, 1'b1, 2'b11, 8'h08, 16'h0F0F, 16'h0000, 1'b0);
    issue(0, 1'b0, 2'b00, 8'h08, 16'h0000, 16'h0F0F, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("sb_empty", i, 32'(sb[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
